spi2reg: RTL and testbench
==========================

SPI2REG -- requirements
Module: spi2reg

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, register address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have port clk  input  1  single system clock; all flops on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sclk  input  1  SPI clock from master; idle low, mode 0.
REQ-006 SHALL have port cs  input  1  SPI chip select, active-low.
REQ-007 SHALL have port mosi  input  1  SPI serial data in, MSB first.
REQ-008 SHALL have port miso  output  1  SPI serial data out, MSB first.
REQ-009 SHALL have port reg_wr_en  output  1  one-cycle register write strobe.
REQ-010 SHALL have port reg_rd_en  output  1  one-cycle register read strobe.
REQ-011 SHALL have port reg_addr  output  ADDR_WIDTH  register address, valid with either strobe.
REQ-012 SHALL have port reg_wdata  output  DATA_WIDTH  write data, valid with reg_wr_en.
REQ-013 SHALL have port reg_rdata  input  DATA_WIDTH  read data, valid exactly one cycle after reg_rd_en.
REQ-014 SHALL have port frame_err  output  1  one-cycle pulse on malformed frame.

Function
REQ-015 SHALL pass sclk, cs, mosi through 2-flop synchronizers plus one edge-detect flop; all decisions use the synchronized versions.
REQ-016 SHALL detect sclk rise/fall and cs fall/rise as one-cycle events from the synchronized stage pair.
REQ-017 SHALL, while cs is low, shift mosi into a (1+ADDR_WIDTH+DATA_WIDTH)-bit shift register and increment a 6-bit bit counter on each sclk rise; the bit counter clears on cs fall.
REQ-018 SHALL decode frames: first bit 1 = write (1+ADDR_WIDTH+DATA_WIDTH = 49 bits: op, addr, data); first bit 0 = read command (1+ADDR_WIDTH = 17 bits: op, addr).
REQ-019 SHALL implement FSM states IDLE, CMD_RCV, WR_ISSUE, RD_ISSUE, RD_CAPTURE, RD_ARMED, RD_SHIFT.
REQ-020 SHALL transition IDLE -> CMD_RCV on cs fall.
REQ-021 SHALL, in CMD_RCV on cs rise: count 49 with op 1 -> WR_ISSUE; count 17 with op 0 -> RD_ISSUE; any other count/op combination -> frame_err pulse, IDLE, no register access.
REQ-022 SHALL, in WR_ISSUE, assert reg_wr_en for one cycle with reg_addr/reg_wdata from the frame, then go to IDLE.
REQ-023 SHALL, in RD_ISSUE, assert reg_rd_en for one cycle with reg_addr from the frame, then go to RD_CAPTURE.
REQ-024 SHALL, in RD_CAPTURE, load reg_rdata into a DATA_WIDTH tx shift register, then go to RD_ARMED; total cs-rise-to-armed latency SHALL be at most 8 clk cycles.
REQ-025 SHALL, in RD_ARMED, go to RD_SHIFT on cs fall, clearing the bit counter.
REQ-026 SHALL drive miso = tx shift register MSB in RD_ARMED and RD_SHIFT, so bit DATA_WIDTH-1 is valid before the first sclk rise; shift left one bit on each sclk fall in RD_SHIFT.
REQ-027 SHALL, in RD_SHIFT on cs rise: count 32 -> IDLE; any other count -> frame_err pulse, IDLE.
REQ-028 SHALL drive miso 0 in all states other than RD_ARMED and RD_SHIFT.
REQ-029 SHALL hold reg_addr and reg_wdata stable from strobe until the next strobe; strobes SHALL never be asserted together.
REQ-030 SHALL ignore sclk edges while synchronized cs is high.
REQ-031 SHALL, if bit counter reaches 63, saturate (no wrap) so oversize frames still flag frame_err.

Reset
REQ-032 SHALL, on rst_n low, asynchronously clear: FSM to IDLE, miso 0, reg_wr_en 0, reg_rd_en 0, frame_err 0, reg_addr 0, reg_wdata 0, shift registers 0, bit counter 0.
REQ-033 SHALL reset cs synchronizer flops to 1 and sclk/mosi synchronizer flops to 0 so no false edge follows reset release.
REQ-034 SHALL, on reset mid-frame, discard the partial frame and issue no register access.

Verification
REQ-035 SHALL cover: write frame op=1, addr 0x1234, data 0xDEADBEEF, sclk period 10 clk -> one reg_wr_en pulse with reg_addr 0x1234, reg_wdata 0xDEADBEEF.
REQ-036 SHALL cover: read cmd op=0, addr 0x00A5, reg_rdata returns 0x5A5AC3C3, cs high 50 clk, then 32 sclk -> reg_rd_en once with addr 0x00A5, master samples 0x5A5AC3C3 on sclk rises.
REQ-037 SHALL cover: write frame truncated after 30 bits -> frame_err pulse, no reg_wr_en.
REQ-038 SHALL cover: read data phase aborted after 10 bits -> frame_err pulse, FSM IDLE, next write frame accepted normally.
REQ-039 SHALL cover: rst_n asserted at bit 20 of a write frame, released, then full write addr 0x0001 data 0x00000002 -> only the second write strobes.
REQ-040 SHALL cover: back-to-back writes with 1-clk cs high gap (addr 0x0010/0x0011) -> two reg_wr_en pulses, correct addresses/data.

Source files
------------

// File: rtl/spi2reg_if.sv
// Pin bundle for the SPI-to-register bridge: SPI slave pins plus the register-bus side.
// The slave modport is the bridge's view; the master modport is the environment's view.
interface spi2reg_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  sclk;
  logic                  cs;
  logic                  mosi;
  logic                  miso;
  logic                  reg_wr_en;
  logic                  reg_rd_en;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [DATA_WIDTH-1:0] reg_wdata;
  logic [DATA_WIDTH-1:0] reg_rdata;
  logic                  frame_err;

  modport slave (
    input  sclk, cs, mosi, reg_rdata,
    output miso, reg_wr_en, reg_rd_en, reg_addr, reg_wdata, frame_err
  );

  modport master (
    output sclk, cs, mosi, reg_rdata,
    input  miso, reg_wr_en, reg_rd_en, reg_addr, reg_wdata, frame_err
  );
endinterface

// File: rtl/spi2reg.sv
// SPI mode-0 slave bridging write frames (op,addr,data) and read commands (op,addr)
// onto a single-cycle strobe register bus; read data is returned in a second cs frame.
module spi2reg #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  spi2reg_if.slave bus
);

  localparam int             FRAME_W   = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam logic [5:0]     WR_BITS   = 6'(FRAME_W);
  localparam logic [5:0]     RD_BITS   = 6'(1 + ADDR_WIDTH);
  localparam logic [5:0]     DATA_BITS = 6'(DATA_WIDTH);
  localparam logic [5:0]     CNT_MAX   = 6'd63;

  typedef enum logic [2:0] {
    IDLE,
    CMD_RCV,
    WR_ISSUE,
    RD_ISSUE,
    RD_CAPTURE,
    RD_ARMED,
    RD_SHIFT
  } state_t;

  state_t state, state_next;

  logic sclk_meta, sclk_sync, sclk_prev;
  logic cs_meta, cs_sync, cs_prev;
  logic mosi_meta, mosi_sync;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  logic [FRAME_W-1:0]    rx;
  logic [DATA_WIDTH-1:0] tx, tx_next;
  logic [5:0]            bit_cnt;
  logic                  err;

  // cs idles high out of reset so releasing rst_n never looks like a cs fall.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_prev <= 1'b0;
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      cs_prev   <= 1'b1;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      sclk_meta <= bus.sclk;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      cs_meta   <= bus.cs;
      cs_sync   <= cs_meta;
      cs_prev   <= cs_sync;
      mosi_meta <= bus.mosi;
      mosi_sync <= mosi_meta;
    end
  end

  // sclk edges only count while the synchronized chip select is asserted.
  assign sclk_rise = sclk_sync & ~sclk_prev & ~cs_sync;
  assign sclk_fall = ~sclk_sync & sclk_prev & ~cs_sync;
  assign cs_fall   = ~cs_sync & cs_prev;
  assign cs_rise   = cs_sync & ~cs_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    err        = 1'b0;
    unique case (state)
      IDLE: begin
        if (cs_fall) state_next = CMD_RCV;
      end
      CMD_RCV: begin
        if (cs_rise) begin
          if (bit_cnt == WR_BITS && rx[FRAME_W-1]) begin
            state_next = WR_ISSUE;
          end else if (bit_cnt == RD_BITS && !rx[ADDR_WIDTH]) begin
            state_next = RD_ISSUE;
          end else begin
            state_next = IDLE;
            err        = 1'b1;
          end
        end
      end
      // A back-to-back frame may start while the strobe is still out.
      WR_ISSUE:   state_next = cs_fall ? CMD_RCV : IDLE;
      RD_ISSUE:   state_next = RD_CAPTURE;
      RD_CAPTURE: state_next = RD_ARMED;
      RD_ARMED: begin
        if (cs_fall) state_next = RD_SHIFT;
      end
      RD_SHIFT: begin
        if (cs_rise) begin
          state_next = IDLE;
          err        = (bit_cnt != DATA_BITS);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_next = tx;
    if (state == RD_CAPTURE) begin
      tx_next = bus.reg_rdata;
    end else if (state == RD_SHIFT && sclk_fall) begin
      tx_next = {tx[DATA_WIDTH-2:0], 1'b0};
    end
  end

  // Outputs are registered off state_next so each strobe lines up with its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.reg_wr_en <= 1'b0;
      bus.reg_rd_en <= 1'b0;
      bus.reg_addr  <= '0;
      bus.reg_wdata <= '0;
      bus.frame_err <= 1'b0;
      bus.miso      <= 1'b0;
      tx            <= '0;
    end else begin
      bus.reg_wr_en <= (state_next == WR_ISSUE);
      bus.reg_rd_en <= (state_next == RD_ISSUE);
      bus.frame_err <= err;
      tx            <= tx_next;
      bus.miso      <= (state_next == RD_ARMED || state_next == RD_SHIFT)
                       ? tx_next[DATA_WIDTH-1] : 1'b0;
      if (state_next == WR_ISSUE) begin
        bus.reg_addr  <= rx[FRAME_W-2 -: ADDR_WIDTH];
        bus.reg_wdata <= rx[DATA_WIDTH-1:0];
      end else if (state_next == RD_ISSUE) begin
        bus.reg_addr  <= rx[ADDR_WIDTH-1:0];
      end
    end
  end

  // Counter saturates so an oversize frame can never alias onto a legal length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx      <= '0;
      bit_cnt <= '0;
    end else if (cs_fall) begin
      bit_cnt <= '0;
    end else if (sclk_rise) begin
      rx <= {rx[FRAME_W-2:0], mosi_sync};
      if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 6'd1;
    end
  end

endmodule

// File: tb/tb_spi2reg.sv
// Directed bench for spi2reg: an SPI master drives frames, a scoreboard checks every
// register strobe and every read word sampled back on miso.
module tb_spi2reg;

  localparam int AW = 16;
  localparam int DW = 32;

  typedef struct {
    logic          is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  spi2reg_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  spi2reg #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int err_cycles = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;

  exp_t        exp_q[$];
  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] rd_value = '0;
  exp_t        mon_e;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Register-file responder: data appears exactly one cycle after the read strobe.
  always @(posedge clk) begin
    bus.reg_rdata <= bus.reg_rd_en ? rd_value : 32'hBAD0_BAD0;
  end

  // Strobe monitor: every strobe pops one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.frame_err === 1'b1) err_cycles++;
      if (bus.reg_wr_en === 1'b1) wr_cnt++;
      if (bus.reg_rd_en === 1'b1) rd_cnt++;
      if (bus.reg_wr_en === 1'b1 || bus.reg_rd_en === 1'b1) begin
        check("strobe_excl", {63'd0, bus.reg_wr_en & bus.reg_rd_en}, 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {62'd0, bus.reg_wr_en, bus.reg_rd_en}, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe_kind", {63'd0, bus.reg_wr_en}, {63'd0, mon_e.is_wr});
          check("strobe_addr", 64'(bus.reg_addr), 64'(mon_e.addr));
          if (mon_e.is_wr) check("strobe_wdata", 64'(bus.reg_wdata), 64'(mon_e.data));
        end
      end
    end
  end

  initial begin
    repeat (40000) @(posedge clk);
    $display("FAIL watchdog: run exceeded cycle budget");
    $fatal(1, "watchdog expired");
  end

  task automatic cs_begin();
    @(negedge clk);
    bus.cs = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic cs_end(input int gap);
    repeat (5) @(negedge clk);
    bus.cs   = 1'b1;
    bus.mosi = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Mode 0: mosi set while sclk low, miso sampled as sclk rises; 10-clk sclk period.
  task automatic xfer(input logic [63:0] bits, input int n, output logic [63:0] sampled);
    sampled = '0;
    for (int i = n - 1; i >= 0; i--) begin
      bus.mosi = bits[i];
      repeat (5) @(negedge clk);
      bus.sclk = 1'b1;
      sampled  = {sampled[62:0], bus.miso};
      repeat (5) @(negedge clk);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic wr_frame(input logic [AW-1:0] addr, input logic [DW-1:0] data, input int gap);
    logic [63:0] s;
    exp_q.push_back('{1'b1, addr, data});
    cs_begin();
    xfer({15'd0, 1'b1, addr, data}, 49, s);
    cs_end(gap);
  endtask

  task automatic rd_cmd(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    logic [63:0] s;
    exp_q.push_back('{1'b0, addr, '0});
    rd_q.push_back(data);
    rd_value = data;
    cs_begin();
    xfer({47'd0, 1'b0, addr}, 17, s);
    cs_end(50);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"},  {63'd0, bus.miso},      64'd0);
    check({tag, "_wr_en"}, {63'd0, bus.reg_wr_en}, 64'd0);
    check({tag, "_rd_en"}, {63'd0, bus.reg_rd_en}, 64'd0);
    check({tag, "_err"},   {63'd0, bus.frame_err}, 64'd0);
    check({tag, "_addr"},  64'(bus.reg_addr),      64'd0);
    check({tag, "_wdata"}, 64'(bus.reg_wdata),     64'd0);
  endtask

  initial begin
    logic [63:0] s;
    logic [DW-1:0] rd_exp;
    int err0;

    bus.cs   = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic write.
    wr_frame(16'h1234, 32'hDEAD_BEEF, 20);
    check("wr1_count", 64'(wr_cnt), 64'd1);
    check("wr1_no_err", 64'(err_cycles), 64'd0);
    check("wr1_addr_hold", 64'(bus.reg_addr), 64'h1234);

    // Read: command frame, armed gap, then 32-bit data phase.
    rd_cmd(16'h00A5, 32'h5A5A_C3C3);
    check("rd_count", 64'(rd_cnt), 64'd1);
    check("rd_armed_msb", {63'd0, bus.miso}, {63'd0, rd_value[DW-1]});
    cs_begin();
    xfer(64'd0, 32, s);
    cs_end(10);
    rd_exp = rd_q.pop_front();
    check("rd_data", s, {32'd0, rd_exp});
    check("rd_idle_miso", {63'd0, bus.miso}, 64'd0);
    check("rd_no_err", 64'(err_cycles), 64'd0);

    // Truncated write: 30 bits of a write frame.
    err0 = err_cycles;
    cs_begin();
    xfer({15'd0, 1'b1, 16'h0BAD, 32'hFFFF_0000} >> 19, 30, s);
    cs_end(10);
    check("trunc_err", 64'(err_cycles), 64'(err0 + 1));
    check("trunc_no_wr", 64'(wr_cnt), 64'd1);

    // Read data phase aborted after 10 bits, then a normal write.
    rd_cmd(16'h0077, 32'hF0F0_0F0F);
    err0 = err_cycles;
    cs_begin();
    xfer(64'd0, 10, s);
    cs_end(10);
    void'(rd_q.pop_front());
    check("abort_err", 64'(err_cycles), 64'(err0 + 1));
    check("abort_miso", {63'd0, bus.miso}, 64'd0);
    wr_frame(16'h0042, 32'h1234_5678, 10);
    check("post_abort_wr", 64'(wr_cnt), 64'd2);

    // Reset in the middle of a write frame: partial frame dropped.
    cs_begin();
    xfer({15'd0, 1'b1, 16'h7777, 32'h8888_9999} >> 29, 20, s);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    bus.cs   = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    wr_frame(16'h0001, 32'h0000_0002, 10);
    check("midreset_wr", 64'(wr_cnt), 64'd3);

    // Back-to-back writes with a single-clock cs high gap.
    wr_frame(16'h0010, 32'hA5A5_0010, 0);
    wr_frame(16'h0011, 32'h5A5A_0011, 10);
    check("b2b_wr", 64'(wr_cnt), 64'd5);

    // Oversize frame: counter saturates and the frame is rejected.
    err0 = err_cycles;
    cs_begin();
    xfer(64'hFFFF_FFFF_FFFF_FFFF, 64, s);
    cs_end(10);
    check("oversize_err", 64'(err_cycles), 64'(err0 + 1));
    check("oversize_no_wr", 64'(wr_cnt), 64'd5);

    repeat (10) @(negedge clk);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    check("rd_total", 64'(rd_cnt), 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
